// File: rtl/lane_serializer.sv
// Parallel-to-lane serializer: DATA_WIDTH-bit words in over valid/ready, LANES-bit beats out, gapless framing.
// Optional SER_PARITY_EN adds a trailer beat carrying the even parity of each word on lane 0.
module lane_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  flush,
  output logic [LANES-1:0]      serial_out,
  output logic                  out_valid,
  output logic                  frame_start,
  output logic                  busy
);

  localparam int DATA_BEATS = DATA_WIDTH / LANES;
`ifdef SER_PARITY_EN
  localparam int BEATS = DATA_BEATS + 1;
`else
  localparam int BEATS = DATA_BEATS;
`endif
  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LOAD_CNT = CW'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [LANES-1:0]      serial_nxt;
  logic                  valid_nxt;
  logic                  start_nxt;
  logic                  load;
`ifdef SER_PARITY_EN
  logic                  parity, parity_nxt;
`endif

  // Beat that leaves next from a (partially consumed) word, and the word with that beat removed.
  function automatic logic [LANES-1:0] head(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) return w[DATA_WIDTH-1 -: LANES];
    else           return w[LANES-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) return w << LANES;
    else           return w >> LANES;
  endfunction

  // cnt==0 in SHIFT marks the final beat of the word, where the next word may be taken.
  assign s_ready = !flush && ((state == IDLE) || (cnt == '0));
  assign load    = s_valid && s_ready;
  assign busy    = (state == SHIFT);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_nxt  = state;
    sreg_nxt   = sreg;
    cnt_nxt    = cnt;
    serial_nxt = serial_out;
    valid_nxt  = out_valid;
    start_nxt  = 1'b0;
`ifdef SER_PARITY_EN
    parity_nxt = parity;
`endif
    if (flush) begin
      state_nxt  = IDLE;
      sreg_nxt   = '0;
      cnt_nxt    = '0;
      serial_nxt = '0;
      valid_nxt  = 1'b0;
    end else if (load) begin
      state_nxt  = SHIFT;
      serial_nxt = head(s_data);
      sreg_nxt   = advance(s_data);
      cnt_nxt    = LOAD_CNT;
      valid_nxt  = 1'b1;
      start_nxt  = 1'b1;
`ifdef SER_PARITY_EN
      parity_nxt = ^s_data;
`endif
    end else if (state == SHIFT && cnt != '0) begin
      cnt_nxt    = cnt - CW'(1);
      sreg_nxt   = advance(sreg);
      serial_nxt = head(sreg);
`ifdef SER_PARITY_EN
      if (cnt == CW'(1)) begin
        serial_nxt    = '0;
        serial_nxt[0] = parity;
      end
`endif
    end else if (state == SHIFT) begin
      state_nxt  = IDLE;
      serial_nxt = '0;
      valid_nxt  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      serial_out  <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
`ifdef SER_PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      sreg        <= sreg_nxt;
      cnt         <= cnt_nxt;
      serial_out  <= serial_nxt;
      out_valid   <= valid_nxt;
      frame_start <= start_nxt;
`ifdef SER_PARITY_EN
      parity      <= parity_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Scoreboard bench for lane_serializer: three configurations (32/4 LSB-first, 8/1 MSB-first, 8/8 MSB-first)
// run side by side, each with a timeline model of accepted words and a monitor comparing every cycle.
module tb_lane_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done [3];

  typedef struct {
    int         at;     // posedge count after which this beat must be on the outputs
    logic [7:0] beat;
    bit         first;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int cfg_dw(input int i);
    return (i == 0) ? 32 : 8;
  endfunction
  function automatic int cfg_ln(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction
  function automatic bit cfg_mf(input int i);
    return (i != 0);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int DW = cfg_dw(g);
    localparam int LN = cfg_ln(g);
    localparam bit MF = cfg_mf(g);
    localparam int DB = DW / LN;
`ifdef SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB   = DB + (PAR ? 1 : 0);
    localparam int HOLD = (DB >= 6) ? 5 : 0;

    logic          rst, s_valid, s_ready, flush, out_valid, frame_start, busy;
    logic [DW-1:0] s_data;
    logic [LN-1:0] serial_out;

    int   cyc = 0;
    int   next_free = 0;
    exp_t q[$];
    exp_t mon_e;

    lane_serializer #(.DATA_WIDTH(DW), .LANES(LN), .MSB_FIRST(MF)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .flush(flush), .serial_out(serial_out), .out_valid(out_valid),
      .frame_start(frame_start), .busy(busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: word accepted at edge `at` shows beat k after edge at+k, then the optional parity trailer.
    task automatic expect_word(input logic [31:0] w, input int at);
      exp_t        e;
      logic [63:0] wm;
      int          sh;
      wm = 64'(w) & ((64'd1 << DW) - 64'd1);
      for (int k = 0; k < DB; k++) begin
        sh      = MF ? (DW - (k + 1) * LN) : (k * LN);
        e.at    = at + k;
        e.beat  = 8'((wm >> sh) & ((64'd1 << LN) - 64'd1));
        e.first = (k == 0);
        q.push_back(e);
      end
      if (PAR) begin
        e.at    = at + DB;
        e.beat  = {7'd0, ^wm};
        e.first = 1'b0;
        q.push_back(e);
      end
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit f, output bit acc);
      int at;
      bit rdy;
      @(negedge clk);
      s_valid = v;
      s_data  = d[DW-1:0];
      flush   = f;
      #1;
      at  = cyc + 1;
      rdy = !f && (at >= next_free);
      check($sformatf("cfg%0d s_ready", g), s_ready, rdy);
      acc = v && rdy;
      if (f) begin
        while (q.size() > 0 && q[$].at >= at) void'(q.pop_back());
        next_free = at + 1;
      end
      if (acc) begin
        expect_word(d, at);
        next_free = at + NB;
      end
    endtask

    task automatic send(input logic [31:0] d);
      bit acc;
      int n;
      n = 0;
      do begin
        step(1'b1, d, 1'b0, acc);
        n++;
      end while (!acc && n < 64);
    endtask

    task automatic idle(input int n);
      bit acc;
      repeat (n) step(1'b0, $urandom, 1'b0, acc);
    endtask

    always @(negedge clk) begin
      if (rst === 1'b1) begin
        if (q.size() > 0 && q[0].at == cyc) begin
          mon_e = q.pop_front();
          check($sformatf("cfg%0d out_valid", g), out_valid, 1'b1);
          check($sformatf("cfg%0d busy", g), busy, 1'b1);
          check($sformatf("cfg%0d serial_out", g), serial_out, mon_e.beat[LN-1:0]);
          check($sformatf("cfg%0d frame_start", g), frame_start, mon_e.first);
        end else begin
          check($sformatf("cfg%0d idle out_valid", g), out_valid, 1'b0);
          check($sformatf("cfg%0d idle busy", g), busy, 1'b0);
          check($sformatf("cfg%0d idle serial_out", g), serial_out, '0);
          check($sformatf("cfg%0d idle frame_start", g), frame_start, 1'b0);
        end
      end
    end

    initial begin
      bit acc;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; flush = 1'b0;
      #1 rst = 1'b0;
      #2;
      check($sformatf("cfg%0d reset out_valid", g), out_valid, 1'b0);
      check($sformatf("cfg%0d reset serial_out", g), serial_out, '0);
      check($sformatf("cfg%0d reset frame_start", g), frame_start, 1'b0);
      check($sformatf("cfg%0d reset busy", g), busy, 1'b0);
      check($sformatf("cfg%0d reset s_ready", g), s_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      next_free = 0;

      // Directed words, offered back to back with s_valid held.
      case (g)
        0: begin send(32'h12345678); send(32'h9ABCDEF0); end
        1: send(32'h000000A5);
        default: begin send(32'h11); send(32'h22); send(32'h33); end
      endcase
      idle(NB + 2);

      // Abort on beat 3 of an all-ones word, with a word offered during the flush cycle.
      send(32'hFFFFFFFF);
      idle(3);
      step(1'b1, 32'h01, 1'b1, acc);
      send(32'h01);
      idle(NB + 2);

      // Random traffic: gaps, held valid, data churn while shifting, occasional flush.
      repeat (400) step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 24) == 0, acc);
      idle(NB + 2);

      // Asynchronous reset in the middle of a word.
      send($urandom);
      @(posedge clk);
      #1 s_valid = 1'b0;
      repeat (HOLD) @(posedge clk);
      #2;
      check($sformatf("cfg%0d in flight before reset", g), out_valid, 1'b1);
      rst = 1'b0;
      #1;
      check($sformatf("cfg%0d async out_valid", g), out_valid, 1'b0);
      check($sformatf("cfg%0d async serial_out", g), serial_out, '0);
      check($sformatf("cfg%0d async frame_start", g), frame_start, 1'b0);
      check($sformatf("cfg%0d async busy", g), busy, 1'b0);
      q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      next_free = 0;
      #1;
      check($sformatf("cfg%0d s_ready after reset", g), s_ready, 1'b1);
      send($urandom);
      idle(NB + 2);
      check($sformatf("cfg%0d scoreboard drained", g), q.size(), 0);
      done[g] = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      checks++;
      errors++;
      $display("FAIL bench timeout: completed=%0d%0d%0d, required=111", done[0], done[1], done[2]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_serializer.md
Name: lane_serializer

Overview:
- Parametrised successor of the single-bit bus serializer.
- Converts DATA_WIDTH-bit parallel words into a stream of LANES-bit beats.
- Uses a valid/ready input handshake, gapless back-to-back framing, selectable bit order and a synchronous abort.
- Sits between the transport-layer word source and the lane adapter / electrical-layer bit pipe.

Parameters:
- DATA_WIDTH, 32, width of the parallel input word; must be a multiple of LANES.
- LANES, 1, bits emitted per clock; legal values 1, 2, 4, 8.
- MSB_FIRST, 1, bit order: 1 = word bit DATA_WIDTH-1 leaves first; 0 = bit 0 leaves first.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- s_valid  input  1  parallel word available
- s_data  input  DATA_WIDTH  parallel word, sampled when s_valid & s_ready
- s_ready  output  1  serializer can accept a word this cycle
- flush  input  1  synchronous abort of the word in flight
- serial_out  output  LANES  current beat
- out_valid  output  1  serial_out carries a valid beat
- frame_start  output  1  high on the first beat of each word
- busy  output  1  word in flight (state SHIFT)

Behaviour:
- Interface: reset rst, asynchronous, active-low; clock clk.
- BEATS = DATA_WIDTH/LANES. Beat counter width is $clog2(BEATS+1).
- Reset values: serial_out=0, out_valid=0, frame_start=0, busy=0, state=IDLE, shift register=0, counter=0.
- FSM states:
  - IDLE: out_valid=0, serial_out=0. On s_valid (s_ready=1), load the word, emit beat 0 on the next edge, counter=BEATS-1, go to SHIFT.
  - SHIFT: each edge emits the next beat and decrements the counter.
  - On the last beat (counter==0 while SHIFT):
    - if s_valid, load the new word and emit its beat 0 on the next edge with no gap;
    - otherwise return to IDLE.
- Latency: word accepted at edge N appears as beat 0 after edge N. serial_out is registered, with no combinational path from s_data.
- s_ready = (state==IDLE) | (state==SHIFT & counter==0), and is 0 while flush is high. s_ready is combinational from state only; it does not depend on s_valid.
- Beat ordering:
  - MSB_FIRST=1: beat k = s_data[DATA_WIDTH-1-k*LANES -: LANES].
  - MSB_FIRST=0: beat k = s_data[k*LANES +: LANES].
  - Within a beat, lane i carries the lower-index bit of the pair when MSB_FIRST=0.
- Outputs per beat: frame_start=1 only with beat 0 of each word. out_valid=1 for every beat. busy=1 whenever in SHIFT.
- flush (synchronous, highest priority after reset):
  - next edge forces IDLE, clears outputs and counter, and drops the word in flight;
  - a word offered on the same cycle is not accepted.
- LANES==DATA_WIDTH: BEATS=1; every accepted word is one beat, and s_ready stays 1 while streaming.
- Asynchronous reset mid-word: immediate return to reset values; the partial word is discarded.
- s_data changes while SHIFT has no effect on the word in flight.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined:
  - one extra trailer beat per word, so BEATS = DATA_WIDTH/LANES + 1;
  - trailer lane 0 = even parity (XOR) of the full word, other lanes 0;
  - out_valid=1, frame_start=0 during the trailer;
  - s_ready asserts on the trailer beat instead of the last data beat.
- Undefined: no trailer beat, and no parity logic is instantiated.

Test Plan:
- Reset then single word, DATA_WIDTH=8, LANES=1, MSB_FIRST=1, s_data=8'hA5 -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles; frame_start only on the first; then out_valid=0, s_ready=1.
- DATA_WIDTH=32, LANES=4, MSB_FIRST=0, two back-to-back words 32'h12345678 then 32'h9ABCDEF0 with s_valid held -> beats 8,7,6,5,4,3,2,1 then 0,F,E,D,C,B,A,9; 16 consecutive out_valid cycles with no gap; frame_start on beats 0 and 8.
- flush asserted on beat 3 of 8'hFF (LANES=1) -> next cycle out_valid=0, busy=0, serial_out=0; the next word 8'h01 serializes cleanly from beat 0.
- rst driven low at beat 5 of a word -> outputs go to 0 immediately without waiting for clk; after release, s_ready=1 in IDLE.
- LANES=DATA_WIDTH=8, s_valid held with words 8'h11, 8'h22, 8'h33 -> one beat per cycle equal to each word; s_ready constantly 1.
- SER_PARITY_EN defined, DATA_WIDTH=8, LANES=1, s_data=8'h07 -> 8 data beats then trailer beat serial_out=1; s_ready high only during the trailer.
